// File: rtl/y86_pkg.sv
// Shared Y86 register codes, controller state encoding and default data width.
package y86_pkg;

    localparam int unsigned DEF_WIDTH = 64;

    localparam logic [3:0] RRAX   = 4'h0;
    localparam logic [3:0] RRCX   = 4'h1;
    localparam logic [3:0] RRDX   = 4'h2;
    localparam logic [3:0] RRBX   = 4'h3;
    localparam logic [3:0] RRSP   = 4'h4;
    localparam logic [3:0] RRBP   = 4'h5;
    localparam logic [3:0] RRSI   = 4'h6;
    localparam logic [3:0] RRDI   = 4'h7;
    localparam logic [3:0] R8     = 4'h8;
    localparam logic [3:0] R9     = 4'h9;
    localparam logic [3:0] R10    = 4'hA;
    localparam logic [3:0] R11    = 4'hB;
    localparam logic [3:0] R12    = 4'hC;
    localparam logic [3:0] R13    = 4'hD;
    localparam logic [3:0] R14    = 4'hE;
    localparam logic [3:0] RRNONE = 4'hF;

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Debug requester handshake: valid/ready request channel plus registered read return.
interface regfile_port_ctrl_if
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             dbg_valid;
    logic             dbg_ready;
    logic             dbg_write;
    logic [3:0]       dbg_reg;
    logic [WIDTH-1:0] dbg_wdata;
    logic             dbg_rvalid;
    logic [WIDTH-1:0] dbg_rdata;

    modport master (
        output dbg_valid, dbg_write, dbg_reg, dbg_wdata,
        input  dbg_ready, dbg_rvalid, dbg_rdata
    );

    modport slave (
        input  dbg_valid, dbg_write, dbg_reg, dbg_wdata,
        output dbg_ready, dbg_rvalid, dbg_rdata
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Owns the register file write ports and read port A: clears r0..r14 after reset, then
// arbitrates between the pipeline and a debug requester, escalating to a stall on starvation.
module regfile_port_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NREGS    = 15,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WCNT_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        p_dstE,
    input  logic [WIDTH-1:0]  p_valE,
    input  logic [3:0]        p_dstM,
    input  logic [WIDTH-1:0]  p_valM,
    input  logic [3:0]        p_srcA,
    output logic [WIDTH-1:0]  p_valA,
    input  logic              pipe_idle,
    output logic              stall_req,
    output logic [3:0]        rf_dstE,
    output logic [WIDTH-1:0]  rf_valE,
    output logic [3:0]        rf_dstM,
    output logic [WIDTH-1:0]  rf_valM,
    output logic [3:0]        rf_srcA,
    input  logic [WIDTH-1:0]  rf_valA,
    output logic              init_done,
    regfile_port_ctrl_if.slave dbg
);

    logic [1:0]        state_q, state_d;
    logic [3:0]        init_cnt_q, init_cnt_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rvalid_q, rvalid_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    logic dbg_ready;
    logic xfer;
    logic wr_ok;
    logic rd_ok;

    assign p_valA         = rf_valA;
    assign init_done      = init_done_q;
    assign dbg.dbg_ready  = dbg_ready;
    assign dbg.dbg_rvalid = rvalid_q;
    assign dbg.dbg_rdata  = rdata_q;

    // Port muxing and handshake.
    always_comb begin
        rf_dstE   = p_dstE;
        rf_valE   = p_valE;
        rf_dstM   = p_dstM;
        rf_valM   = p_valM;
        rf_srcA   = p_srcA;
        stall_req = 1'b0;
        dbg_ready = 1'b0;
        wr_ok     = dbg.dbg_write & (p_dstE == RRNONE) & (p_dstM == RRNONE);
        rd_ok     = ~dbg.dbg_write & (p_srcA == RRNONE);

        case (state_q)
            RUN: begin
                dbg_ready = dbg.dbg_valid & (pipe_idle | wr_ok | rd_ok);
            end
            FORCE: begin
                stall_req = 1'b1;
                dbg_ready = dbg.dbg_valid & pipe_idle;
            end
            default: begin
                rf_dstE   = init_cnt_q;
                rf_valE   = '0;
                rf_dstM   = RRNONE;
                rf_valM   = '0;
                rf_srcA   = RRNONE;
                stall_req = 1'b1;
            end
        endcase

        xfer = dbg.dbg_valid & dbg_ready;

        if (xfer) begin
            if (dbg.dbg_write) begin
                rf_dstE = dbg.dbg_reg;
                rf_valE = dbg.dbg_wdata;
                rf_dstM = RRNONE;
            end else begin
                rf_srcA = dbg.dbg_reg;
            end
        end
    end

    // Sequencing, starvation counter and read-data capture.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        init_done_d = init_done_q;
        rvalid_d    = xfer & ~dbg.dbg_write;
        rdata_d     = rdata_q;

        // Code F has no backing register, so its read value is defined as zero here.
        if (xfer && !dbg.dbg_write) begin
            rdata_d = (dbg.dbg_reg == RRNONE) ? '0 : rf_valA;
        end

        case (state_q)
            RUN: begin
                if (!dbg.dbg_valid || xfer) begin
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == WCNT_W'(MAX_WAIT)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                if (!dbg.dbg_valid || xfer) begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            default: begin
                wait_cnt_d = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == 4'(NREGS - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            init_done_q <= init_done_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule
